// File: rtl/tpu_pkg.sv
// Shared widths and operand types for the systolic-array processing elements.
// Cells may override the widths through their own parameters.
package tpu_pkg;

   localparam int DATA_W = 8;
   localparam int ACC_W  = 32;

   typedef logic [DATA_W-1:0] data_t;
   typedef logic [ACC_W-1:0]  acc_t;

endpackage

// File: rtl/mac_weight_buf.sv
// Double-buffered weight store: a shadow register fed by the weight chain and
// an active register that feeds the multiplier.
module mac_weight_buf
   import tpu_pkg::*;
#(
   parameter int W = tpu_pkg::DATA_W
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         load,
   input  logic         swap,
   input  logic [W-1:0] d,
   output logic [W-1:0] shadow_q,
   output logic [W-1:0] active_q
);

   // When load and swap coincide, the incoming weight goes straight into
   // both registers, so a single cycle makes it usable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_q <= '0;
         active_q <= '0;
      end else if (load && swap) begin
         shadow_q <= d;
         active_q <= d;
      end else if (load) begin
         shadow_q <= d;
      end else if (swap) begin
         active_q <= shadow_q;
      end
   end

endmodule

// File: rtl/mac.sv
// Weight-stationary multiply-accumulate cell: one registered stage computing
// acc_out = acc_in + data_in * active_weight (signed), forwarding data_in.
module mac
   import tpu_pkg::*;
#(
   parameter int DATA_W = tpu_pkg::DATA_W,
   parameter int ACC_W  = tpu_pkg::ACC_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load_weight,
   input  logic              swap_weights,
   input  logic              run,
   input  logic [DATA_W-1:0] weight_in,
   output logic [DATA_W-1:0] weight_out,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   input  logic [ACC_W-1:0]  acc_in,
   output logic [ACC_W-1:0]  acc_out
);

   logic [DATA_W-1:0]          active_w;
   logic signed [2*DATA_W-1:0] product;
   logic signed [ACC_W-1:0]    product_ext;

   mac_weight_buf #(
      .W (DATA_W)
   ) u_weight_buf (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load_weight),
      .swap     (swap_weights),
      .d        (weight_in),
      .shadow_q (weight_out),
      .active_q (active_w)
   );

   // The multiplier sees the active weight from before the edge, so a swap
   // on the same cycle only affects the next run.
   assign product     = $signed(data_in) * $signed(active_w);
   assign product_ext = ACC_W'(product);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_out  <= '0;
         data_out <= '0;
      end else if (run) begin
         acc_out  <= acc_in + product_ext;
         data_out <= data_in;
      end
   end

endmodule

// File: tb/tb_mac.sv
// Self-checking bench for mac: directed vectors plus random traffic checked
// against a behavioural model built from signed integer arithmetic.
module tb_mac;
   import tpu_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        load_weight;
   logic        swap_weights;
   logic        run;
   logic [7:0]  weight_in;
   logic [7:0]  weight_out;
   logic [7:0]  data_in;
   logic [7:0]  data_out;
   logic [31:0] acc_in;
   logic [31:0] acc_out;

   int checks   = 0;
   int failures = 0;

   // Reference model state
   byte m_shadow;
   byte m_active;
   int  m_acc;
   byte m_dout;

   mac #(
      .DATA_W (8),
      .ACC_W  (32)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .load_weight  (load_weight),
      .swap_weights (swap_weights),
      .run          (run),
      .weight_in    (weight_in),
      .weight_out   (weight_out),
      .data_in      (data_in),
      .data_out     (data_out),
      .acc_in       (acc_in),
      .acc_out      (acc_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic modelReset();
      m_shadow = 0;
      m_active = 0;
      m_acc    = 0;
      m_dout   = 0;
   endtask

   task automatic checkModel(input string tag);
      checkOutput({tag, "_acc"},  acc_out,            m_acc);
      checkOutput({tag, "_dout"}, {24'd0, data_out},  {24'd0, m_dout});
      checkOutput({tag, "_wout"}, {24'd0, weight_out}, {24'd0, m_shadow});
   endtask

   // Drive one cycle of inputs, advance the model over the edge, then check.
   task automatic applyStimulus(input bit ld, input bit sw, input bit rn,
                                input byte w, input byte d, input int a,
                                input string tag);
      load_weight  = ld;
      swap_weights = sw;
      run          = rn;
      weight_in    = w;
      data_in      = d;
      acc_in       = a;
      @(posedge clk);
      #1;
      if (rn) begin
         m_acc  = a + int'(d) * int'(m_active);
         m_dout = d;
      end
      if (ld && sw) begin
         m_shadow = w;
         m_active = w;
      end else if (ld) begin
         m_shadow = w;
      end else if (sw) begin
         m_active = m_shadow;
      end
      checkModel(tag);
   endtask

   initial begin
      rst_n        = 1'b0;
      load_weight  = 1'b0;
      swap_weights = 1'b0;
      run          = 1'b0;
      weight_in    = '0;
      data_in      = '0;
      acc_in       = '0;
      modelReset();
      #1;
      checkModel("reset");
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Basic bypass load then one MAC step
      applyStimulus(1, 1, 0, 57, 0, 0, "ld57");
      applyStimulus(0, 0, 1, 0, 94, 0, "run94");
      checkOutput("vec_acc5358", acc_out, 32'd5358);
      checkOutput("vec_dout94", {24'd0, data_out}, 32'd94);
      checkOutput("vec_wout57", {24'd0, weight_out}, 32'd57);

      // Shadow load without swap keeps using the old weight
      applyStimulus(1, 0, 0, 3, 0, 0, "ld3");
      applyStimulus(0, 0, 1, 0, 2, 10, "run_old");
      checkOutput("vec_acc124", acc_out, 32'd124);
      checkOutput("vec_wout3", {24'd0, weight_out}, 32'd3);
      applyStimulus(0, 1, 0, 0, 0, 0, "swap3");
      applyStimulus(0, 0, 1, 0, 2, 10, "run_new");
      checkOutput("vec_acc16", acc_out, 32'd16);

      // Run and swap on the same edge: multiply uses pre-edge active weight
      applyStimulus(1, 0, 0, 7, 0, 0, "ld7");
      applyStimulus(0, 1, 1, 0, 4, 1, "run_swap");
      checkOutput("vec_runswap13", acc_out, 32'd13);

      // Signed operands
      applyStimulus(1, 1, 0, -2, 0, 0, "ldneg2");
      applyStimulus(0, 0, 1, 0, 100, 0, "runneg");
      checkOutput("vec_signed", acc_out, 32'hFFFF_FF38);

      // Wraparound
      applyStimulus(1, 1, 0, 1, 0, 0, "ld1");
      applyStimulus(0, 0, 1, 0, 1, 32'hFFFF_FFFF, "runwrap");
      checkOutput("vec_wrap", acc_out, 32'h0);

      // Hold with run low while inputs change
      for (int i = 0; i < 3; i++)
         applyStimulus(0, 0, 0, 0, byte'($urandom), int'($urandom), "hold");
      checkOutput("vec_hold_acc", acc_out, 32'h0);
      checkOutput("vec_hold_dout", {24'd0, data_out}, 32'd1);

      // Mid-cycle asynchronous reset after loading
      applyStimulus(1, 1, 0, 9, 0, 0, "ld9");
      applyStimulus(0, 0, 1, 0, 3, 5, "run9");
      #2;
      rst_n = 1'b0;
      #1;
      modelReset();
      checkModel("async_reset");
      checkOutput("vec_rst_acc", acc_out, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(0, 0, 1, 0, 5, 77, "run_after_rst");
      checkOutput("vec_rst_run", acc_out, 32'd77);

      // Random traffic against the model
      for (int i = 0; i < 300; i++) begin
         applyStimulus(bit'($urandom_range(0, 3) == 0), bit'($urandom_range(0, 3) == 0),
                       bit'($urandom_range(0, 1)), byte'($urandom), byte'($urandom),
                       int'($urandom), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/mac.md
MAC -- requirements
Module: mac

Interface
REQ-001 The module SHALL have parameter DATA_W, default 8, the width of data and weight operands.
REQ-002 The module SHALL have parameter ACC_W, default 32, the width of the partial-sum accumulator path.
REQ-003 One clock; reset is asynchronous and active-low (ports clk, rst_n).
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 rst_n  input  1  asynchronous active-low reset.
REQ-006 load_weight  input  1  capture weight_in into the shadow weight register.
REQ-007 swap_weights  input  1  transfer the shadow weight into the active weight register.
REQ-008 run  input  1  perform one multiply-accumulate step this cycle.
REQ-009 weight_in  input  DATA_W  weight from the upstream neighbour.
REQ-010 weight_out  output  DATA_W  shadow weight, daisy-chained to the downstream neighbour.
REQ-011 data_in  input  DATA_W  activation from the left neighbour.
REQ-012 data_out  output  DATA_W  registered activation forwarded to the right neighbour.
REQ-013 acc_in  input  ACC_W  partial sum from the upstream neighbour.
REQ-014 acc_out  output  ACC_W  registered partial sum to the downstream neighbour.

Function
REQ-015 Weights SHALL be double-buffered in a shadow register and an active register, each DATA_W bits.
REQ-016 On a rising edge with load_weight=1, shadow SHALL be set to weight_in.
REQ-017 On a rising edge with swap_weights=1 and load_weight=0, active SHALL be set to shadow.
REQ-018 On a rising edge with both load_weight=1 and swap_weights=1, shadow and active SHALL both be set to weight_in (bypass).
REQ-019 weight_out SHALL equal the shadow register, giving one cycle of latency per cell along a weight chain.
REQ-020 On a rising edge with run=1, acc_out SHALL become acc_in + sext(data_in) * sext(active), with operands signed two's complement.
REQ-021 The product SHALL be sign-extended to ACC_W, and the sum SHALL wrap modulo 2^ACC_W with no saturation and no overflow flag.
REQ-022 On the same rising edge with run=1, data_out SHALL become data_in.
REQ-023 The multiply-accumulate latency SHALL be exactly 1 cycle, with results visible after the edge that sampled run=1.
REQ-024 With run=0, acc_out and data_out SHALL hold their values.
REQ-025 The weight registers SHALL be unaffected by run.
REQ-026 When run=1 and swap_weights=1 on the same edge, the multiply SHALL use the active weight from before the edge.
REQ-027 An X or unknown run SHALL be treated as 0 by verification; the design need not guarantee behaviour under X.

Reset
REQ-028 While rst_n=0, the shadow register, active register, weight_out, data_out and acc_out SHALL be 0, asynchronously.
REQ-029 Reset asserted mid-operation SHALL discard all weights and partial sums.
REQ-030 After reset release, the block SHALL be idle until the next load_weight, swap_weights or run.

Structure
REQ-031 DATA_W and ACC_W defaults SHALL live in shared package tpu_pkg as localparams, alongside typedefs data_t (DATA_W) and acc_t (ACC_W).
REQ-032 The double buffer MAY be a sub-module mac_weight_buf, with ports clk, rst_n, load, swap, d, shadow_q and active_q.
REQ-033 The datapath SHALL be a single registered multiply-add stage with no internal pipelining.

Verification
REQ-034 Reset, then weight_in=57 with load_weight=1 and swap_weights=1 for 1 cycle, then data_in=94, acc_in=0, run=1 for 1 cycle -> acc_out=5358, data_out=94, weight_out=57.
REQ-035 Active weight 57; load weight_in=3 without swap; run with data_in=2, acc_in=10 -> acc_out=124 (old weight used), weight_out=3; then swap and rerun -> acc_out=16.
REQ-036 Signed operands: weight=-2 (8'hFE), data_in=100, acc_in=0, run -> acc_out=32'hFFFFFF38 (-200).
REQ-037 Wraparound: weight=1, data_in=1, acc_in=32'hFFFFFFFF, run -> acc_out=0.
REQ-038 run=0 for 3 cycles with changing data_in and acc_in -> acc_out and data_out unchanged.
REQ-039 Assert rst_n=0 asynchronously mid-cycle after loading -> all outputs 0 immediately; a subsequent run with data_in=5 -> acc_out=acc_in (active weight 0).
